// File: rtl/constant.sv
// Shared pipeline control types: register update codes,
// sequencer mode encoding and PC helpers.
package constant;

  typedef enum logic [1:0] {
    UPD_HOLD  = 2'b00,
    UPD_ADV   = 2'b01,
    UPD_FLUSH = 2'b10
  } upd_t;

  typedef enum logic [1:0] {
    BOOT_WAIT,
    LOAD,
    EXEC,
    STOP
  } mode_t;

  localparam int unsigned PC_STEP = 4;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/pipe_perf_ctr.sv
// Retired / flush / stall event counters for the sequencer.
// Cleared on program start, frozen whenever execution is idle.
module pipe_perf_ctr (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_ret,
  input  logic        i_flush,
  input  logic        i_stall,
  output logic [31:0] o_retired,
  output logic [31:0] o_flushes,
  output logic [31:0] o_stalls
);

  logic [31:0] r_ret;
  logic [31:0] r_fl;
  logic [31:0] r_st;

  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      r_ret <= '0;
      r_fl  <= '0;
      r_st  <= '0;
    end else if (i_en) begin
      r_ret <= r_ret + 32'(i_ret);
      r_fl  <= r_fl + 32'(i_flush);
      r_st  <= r_st + 32'(i_stall);
    end
  end

  assign o_retired = r_ret;
  assign o_flushes = r_fl;
  assign o_stalls  = r_st;

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: boot/load/exec/stop FSM, architectural PC,
// stage register update codes and execute latency tracking.
module pipe_sequencer
  import constant::*;
#(
  parameter int unsigned BOOT_WAIT_CYCLES = 10000,
  parameter int          LAT_W            = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_done,
  input  logic             tx_ack,
  input  logic             de_stop,
  input  logic [LAT_W-1:0] de_wait_time,
  input  logic             uart_busy,
  input  logic             d_jump,
  input  logic             d_is_jr,
  input  logic [31:0]      d_npc,
  input  logic             ew_redirect,
  input  logic [31:0]      ew_target,
  input  logic             restart,
  output mode_t            mode,
  output logic [31:0]      pc,
  output upd_t             fd_update,
  output upd_t             de_update,
  output upd_t             ew_update,
  output logic             e_start,
  output logic [LAT_W-1:0] latency,
  output logic [31:0]      retired,
  output logic [31:0]      flushes,
  output logic [31:0]      stalls
);

  mode_t            r_mode;
  logic [31:0]      r_pc;
  logic [31:0]      r_boot;
  logic [LAT_W-1:0] r_lat;
  logic             r_est;

  logic             w_exec;
  logic             w_npc_stall;
  logic             w_done;
  logic             w_redir;
  logic             w_adv;
  logic             w_hold;
  logic             w_start;
  logic [LAT_W-1:0] w_lat_inc;
  upd_t             w_upd;

  assign w_exec      = (r_mode == EXEC);
  assign w_npc_stall = w_exec && (d_jump || d_is_jr) && (r_lat == '0);
  assign w_done      = w_exec && (r_lat >= de_wait_time)
                       && !uart_busy && !w_npc_stall;
  assign w_redir     = w_exec && ew_redirect;
  assign w_adv       = w_done && !w_redir;
  assign w_hold      = w_exec && !w_redir && !w_done;
  assign w_start     = (r_mode == LOAD) && load_done && tx_ack;
  assign w_lat_inc   = (r_lat == '1) ? r_lat : r_lat + 1'b1;

  always_comb begin
    w_upd = UPD_HOLD;
    unique case (1'b1)
      !w_exec || w_redir: w_upd = UPD_FLUSH;
      w_adv:              w_upd = UPD_ADV;
      default:            w_upd = UPD_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mode <= BOOT_WAIT;
      r_pc   <= '0;
      r_boot <= '0;
      r_lat  <= '0;
      r_est  <= 1'b0;
    end else begin
      r_est <= w_adv;
      unique case (r_mode)
        BOOT_WAIT: begin
          if (r_boot == BOOT_WAIT_CYCLES) r_mode <= LOAD;
          else                           r_boot <= r_boot + 1;
        end
        LOAD: if (w_start) r_mode <= EXEC;
        EXEC: begin
          if (w_redir)          r_pc <= align4(ew_target);
          else if (w_adv)       r_pc <= align4(r_pc + PC_STEP);
          else if (w_npc_stall) r_pc <= align4(d_npc);
          // a retiring or squashed instruction restarts the count
          if (w_redir || w_adv)
            r_lat <= '0;
          else if (r_lat < de_wait_time || w_npc_stall)
            r_lat <= w_lat_inc;
          if (de_stop) r_mode <= STOP;
        end
        STOP: begin
          if (restart) begin
            r_mode <= LOAD;
            r_pc   <= '0;
            r_lat  <= '0;
          end
        end
        default: r_mode <= BOOT_WAIT;
      endcase
    end
  end

  pipe_perf_ctr u_ctr (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_start),
    .i_en      (w_exec),
    .i_ret     (w_adv),
    .i_flush   (w_redir),
    .i_stall   (w_hold),
    .o_retired (retired),
    .o_flushes (flushes),
    .o_stalls  (stalls)
  );

  assign mode      = r_mode;
  assign pc        = r_pc;
  assign latency   = r_lat;
  assign e_start   = r_est;
  assign fd_update = w_upd;
  assign de_update = w_upd;
  assign ew_update = w_upd;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_pipe_sequencer;
  import constant::*;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_done;
  logic        tx_ack;
  logic        de_stop;
  logic [4:0]  de_wait_time;
  logic        uart_busy;
  logic        d_jump;
  logic        d_is_jr;
  logic [31:0] d_npc;
  logic        ew_redirect;
  logic [31:0] ew_target;
  logic        restart;

  mode_t       mode;
  logic [31:0] pc;
  upd_t        fd_update;
  upd_t        de_update;
  upd_t        ew_update;
  logic        e_start;
  logic [4:0]  latency;
  logic [31:0] retired;
  logic [31:0] flushes;
  logic [31:0] stalls;

  always #5 clk = ~clk;

  pipe_sequencer #(
    .BOOT_WAIT_CYCLES (BW),
    .LAT_W            (5)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_done    (load_done),
    .tx_ack       (tx_ack),
    .de_stop      (de_stop),
    .de_wait_time (de_wait_time),
    .uart_busy    (uart_busy),
    .d_jump       (d_jump),
    .d_is_jr      (d_is_jr),
    .d_npc        (d_npc),
    .ew_redirect  (ew_redirect),
    .ew_target    (ew_target),
    .restart      (restart),
    .mode         (mode),
    .pc           (pc),
    .fd_update    (fd_update),
    .de_update    (de_update),
    .ew_update    (ew_update),
    .e_start      (e_start),
    .latency      (latency),
    .retired      (retired),
    .flushes      (flushes),
    .stalls       (stalls)
  );

  // model state: mode 0=boot 1=load 2=exec 3=stop
  int          m_mode;
  int          m_boot;
  int          m_lat;
  bit          m_est;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_fl;
  logic [31:0] m_st;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_npc_stall();
    return (d_jump || d_is_jr) && m_lat == 0;
  endfunction

  function automatic bit m_done();
    return m_lat >= int'(de_wait_time) && !uart_busy
           && !m_npc_stall();
  endfunction

  function automatic int exp_upd();
    if (m_mode != 2) return 2;
    if (ew_redirect) return 2;
    if (m_done())    return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_boot = 0;
    m_lat  = 0;
    m_est  = 0;
    m_pc   = 0;
    m_ret  = 0;
    m_fl   = 0;
    m_st   = 0;
  endtask

  task automatic model_step();
    bit red, sn, dn, adv;
    int wt;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_est = 0;
    case (m_mode)
      0: if (m_boot == BW) m_mode = 1; else m_boot++;
      1: if (load_done && tx_ack) begin
           m_mode = 2;
           m_ret = 0;
           m_fl = 0;
           m_st = 0;
         end
      2: begin
        wt  = int'(de_wait_time);
        red = ew_redirect;
        sn  = m_npc_stall();
        dn  = m_done();
        adv = dn && !red;
        m_est = adv;
        if (red)      m_fl++;
        else if (adv) m_ret++;
        else          m_st++;
        if (red)      m_pc = ew_target & ~32'h3;
        else if (adv) m_pc = m_pc + 4;
        else if (sn)  m_pc = d_npc & ~32'h3;
        if (red || adv)           m_lat = 0;
        else if (m_lat < wt || sn) m_lat = (m_lat >= 31) ? 31 : m_lat + 1;
        if (de_stop) m_mode = 3;
      end
      default: if (restart) begin
        m_mode = 1;
        m_pc = 0;
        m_lat = 0;
      end
    endcase
  endtask

  task automatic check_all();
    check("mode", 32'(mode), 32'(m_mode));
    check("pc", pc, m_pc);
    check("fd_upd", 32'(fd_update), 32'(exp_upd()));
    check("de_upd", 32'(de_update), 32'(exp_upd()));
    check("ew_upd", 32'(ew_update), 32'(exp_upd()));
    check("e_start", 32'(e_start), 32'(m_est));
    check("latency", 32'(latency), 32'(m_lat));
    check("retired", retired, m_ret);
    check("flushes", flushes, m_fl);
    check("stalls", stalls, m_st);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rstn = 0; load_done = 0; tx_ack = 0; de_stop = 0;
    de_wait_time = 0; uart_busy = 0; d_jump = 0; d_is_jr = 0;
    d_npc = 0; ew_redirect = 0; ew_target = 0; restart = 0;
    @(posedge clk);
    model_reset();
    #1;
    step();
    check("rst_mode", 32'(mode), 32'(BOOT_WAIT));
    check("rst_pc", pc, 32'h0);
    check("rst_upd", 32'(fd_update), 32'(UPD_FLUSH));
    rstn = 1;

    // boot wait then load handshake
    repeat (BW + 1) step();
    check("boot_load", 32'(mode), 32'(LOAD));
    load_done = 1;
    repeat (5) step();
    check("load_hold", 32'(mode), 32'(LOAD));
    tx_ack = 1;
    step();
    check("exec_in", 32'(mode), 32'(EXEC));
    check("exec_ret0", retired, 32'h0);
    load_done = 0; tx_ack = 0;

    // multi-cycle execute
    de_wait_time = 3;
    repeat (3) step();
    #1;
    check("t2_adv", 32'(de_update), 32'(UPD_ADV));
    step();
    check("t2_pc", pc, 32'h4);
    check("t2_est", 32'(e_start), 32'h1);
    check("t2_stalls", stalls, 32'd3);
    check("t2_ret", retired, 32'd1);

    // jump next-pc stall
    de_wait_time = 0; d_jump = 1; d_npc = 32'h40;
    #1;
    check("t3_hold", 32'(fd_update), 32'(UPD_HOLD));
    step();
    check("t3_pc", pc, 32'h40);
    check("t3_lat", 32'(latency), 32'd1);
    check("t3_adv", 32'(ew_update), 32'(UPD_ADV));
    step();
    check("t3_pc2", pc, 32'h44);
    d_jump = 0;

    // redirect beats done
    ew_redirect = 1; ew_target = 32'h103;
    #1;
    check("t4_fd", 32'(fd_update), 32'(UPD_FLUSH));
    check("t4_ew", 32'(ew_update), 32'(UPD_FLUSH));
    step();
    check("t4_pc", pc, 32'h100);
    check("t4_fl", flushes, 32'd1);
    check("t4_ret", retired, 32'd2);
    ew_redirect = 0;

    // stop and restart
    de_wait_time = 3; de_stop = 1;
    step();
    check("t5_stop", 32'(mode), 32'(STOP));
    de_stop = 0;
    repeat (10) step();
    check("t5_pc", pc, 32'h100);
    check("t5_upd", 32'(de_update), 32'(UPD_FLUSH));
    restart = 1;
    step();
    check("t5_load", 32'(mode), 32'(LOAD));
    check("t5_pc0", pc, 32'h0);
    restart = 0;

    // reset mid-stall
    load_done = 1; tx_ack = 1;
    step();
    load_done = 0; tx_ack = 0; de_wait_time = 5;
    repeat (2) step();
    check("t6_lat2", 32'(latency), 32'd2);
    rstn = 0;
    step();
    check("t6_mode", 32'(mode), 32'(BOOT_WAIT));
    check("t6_lat", 32'(latency), 32'h0);
    check("t6_est", 32'(e_start), 32'h0);
    rstn = 1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rstn         = ($urandom_range(0, 199) != 0);
      load_done    = $urandom_range(0, 1) == 1;
      tx_ack       = $urandom_range(0, 1) == 1;
      de_stop      = ($urandom_range(0, 24) == 0);
      restart      = ($urandom_range(0, 2) == 0);
      uart_busy    = ($urandom_range(0, 4) == 0);
      d_jump       = ($urandom_range(0, 5) == 0);
      d_is_jr      = ($urandom_range(0, 9) == 0);
      ew_redirect  = ($urandom_range(0, 7) == 0);
      d_npc        = $urandom;
      ew_target    = $urandom;
      de_wait_time = ($urandom_range(0, 19) == 0) ?
                     5'($urandom_range(0, 31)) :
                     5'($urandom_range(0, 4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
